// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master among NUM_REQ requesters.
// One transaction in flight; a watchdog turns a lost R beat into an error response.
module axi4_lite_read_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*3-1:0]              req_prot_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]         rsp_data_o,
    output logic                              rsp_err_o,
    output logic                              AR_VALID,
    output logic [AXI_ADDR_WIDTH-1:0]         AR_ADDR,
    output logic [2:0]                        AR_PROT,
    input  logic                              AR_READY,
    input  logic                              R_VALID,
    input  logic [AXI_DATA_WIDTH-1:0]         R_DATA,
    input  logic [1:0]                        R_RESP,
    output logic                              R_READY
);

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]                r_state;
    logic [IW-1:0]             r_rr_ptr;
    logic [IW-1:0]             r_gnt;
    logic                      r_drain;
    logic [CW-1:0]             r_cnt;
    logic [AXI_ADDR_WIDTH-1:0] r_ar_addr;
    logic [2:0]                r_ar_prot;
    logic [AXI_DATA_WIDTH-1:0] r_rsp_data;
    logic                      r_rsp_err;

    // Packed-array views of the flat request buses; slice i belongs to requester i.
    logic [NUM_REQ-1:0][AXI_ADDR_WIDTH-1:0] w_addr;
    logic [NUM_REQ-1:0][2:0]                w_prot;
    logic                                   w_gnt_vld;
    logic [IW-1:0]                          w_gnt_idx;
    logic [CW-1:0]                          w_cnt_nxt;
    logic                                   w_timeout;
    logic                                   w_unused;

    assign w_addr    = req_addr_i;
    assign w_prot    = req_prot_i;
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_timeout = WDOG_EN && (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
    assign w_unused  = R_RESP[0];

    // Rotating priority: first requester at or above rr_ptr, wrapping.
    always_comb begin
        int w_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_gnt_vld && req_valid_i[IW'(w_idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(w_idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (r_state == S_IDLE && w_gnt_vld) req_ready_o[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid_o = '0;
        if (r_state == S_RESP) rsp_valid_o[r_gnt] = 1'b1;
    end

    assign AR_VALID   = (r_state == S_ADDR);
    assign R_READY    = (r_state == S_DATA) || (r_state == S_DRAIN);
    assign AR_ADDR    = r_ar_addr;
    assign AR_PROT    = r_ar_prot;
    assign rsp_data_o = r_rsp_data;
    assign rsp_err_o  = r_rsp_err;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_drain    <= 1'b0;
            r_cnt      <= '0;
            r_ar_addr  <= '0;
            r_ar_prot  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt     <= w_gnt_idx;
                        r_ar_addr <= w_addr[w_gnt_idx];
                        r_ar_prot <= w_prot[w_gnt_idx];
                        r_rr_ptr  <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + IW'(1);
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (AR_READY) r_state <= S_DATA;
                end
                S_DATA: begin
                    // A beat arriving in the timeout cycle wins; nothing is left to drain.
                    if (R_VALID) begin
                        r_rsp_data <= R_DATA;
                        r_rsp_err  <= R_RESP[1];
                        r_cnt      <= '0;
                        r_state    <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_cnt      <= '0;
                        r_drain    <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (WDOG_EN) begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_RESP: begin
                    r_state <= r_drain ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (R_VALID) begin
                        r_drain <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_ar_r_excl: assert property (@(posedge clk_i) disable iff (!arst_ni)
        !(AR_VALID && R_READY));
    a_ar_hold: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (AR_VALID && !AR_READY) |=> (AR_VALID && $stable(AR_ADDR) && $stable(AR_PROT)));
    a_onehot: assert property (@(posedge clk_i) disable iff (!arst_ni)
        $onehot0(rsp_valid_o) && $onehot0(req_ready_o));

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

Shares one AXI4-Lite read master port between `NUM_REQ` internal requesters (instruction fetch, data load, page walker) in front of the external-memory read slave. Arbitration is round-robin, with one transaction in flight at a time. Each accepted request is driven through the AR and R channels, and the response is routed back to the originating requester. A response watchdog converts a lost R beat into an error response, so that a requester can never hang.

## Interface
- `NUM_REQ`, 2 — number of requesters (2..8).
- `AXI_ADDR_WIDTH`, 64 — address width.
- `AXI_DATA_WIDTH`, 32 — data width.
- `TIMEOUT_CYCLES`, 1024 — cycles allowed in DATA before a timeout; 0 disables the watchdog.
- `clk_i`  in  1  clock; all logic is on its rising edge.
- `arst_ni`  in  1  reset, asynchronous and active-low.
- `req_valid_i`  in  `NUM_REQ`  per-requester read request.
- `req_addr_i`  in  `NUM_REQ*AXI_ADDR_WIDTH`  request addresses, packed; requester i uses slice i.
- `req_prot_i`  in  `NUM_REQ*3`  request AxPROT values, packed.
- `req_ready_o`  out  `NUM_REQ`  request accepted (combinational, one-hot).
- `rsp_valid_o`  out  `NUM_REQ`  one-cycle response pulse (one-hot).
- `rsp_data_o`  out  `AXI_DATA_WIDTH`  response data, shared by all requesters.
- `rsp_err_o`  out  1  response is an error (SLVERR, DECERR or timeout).
- `AR_VALID`, `AR_ADDR`, `AR_PROT`  out  1/`AXI_ADDR_WIDTH`/3  read address channel.
- `AR_READY`  in  1.
- `R_VALID`  in  1.
- `R_DATA`  in  `AXI_DATA_WIDTH`.
- `R_RESP`  in  2.
- `R_READY`  out  1.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DRAIN. Reset state is IDLE.
- **IDLE**:
  - If any `req_valid_i` bit is set, grant `g` is the first set bit at or after `rr_ptr`, searching upward with wrap.
  - `req_ready_o[g]` = 1 combinationally, only in IDLE.
  - On that edge, register `g`, `addr[g]` into `AR_ADDR` and `prot[g]` into `AR_PROT`. Set `rr_ptr` = (g+1) mod `NUM_REQ`. Go to ADDR.
- **ADDR**: `AR_VALID`=1. `AR_ADDR` and `AR_PROT` are held stable. On `AR_READY`, go to DATA.
- **DATA**:
  - `R_READY`=1. The watchdog counter increments each cycle.
  - On `R_VALID`: capture `R_DATA` into `rsp_data_o`, set `rsp_err_o` = `R_RESP[1]`, clear the counter, go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` (when nonzero) before `R_VALID`: set `rsp_data_o`=0 and `rsp_err_o`=1, go to RESP with the drain flag set.
  - If `R_VALID` and the timeout occur in the same cycle, the R beat wins and no drain is needed.
- **RESP**: `rsp_valid_o[g]`=1 for exactly one cycle. Then go to DRAIN if the drain flag is set, otherwise IDLE.
- **DRAIN**:
  - `R_READY`=1 and no grants are issued.
  - The late R beat is accepted and discarded, with no `rsp_valid_o`. Then clear the drain flag and go to IDLE.
- A requester holds `req_valid_i` and `req_addr_i` until it sees `req_ready_o`. The arbiter never needs them after the grant edge.
- Requester changes on `req_valid_i` in non-IDLE states are ignored.
- Reset values:
  - FSM state: IDLE.
  - `rr_ptr`: 0.
  - `AR_VALID`, `R_READY`, `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, drain flag, counter: 0.
  - `AR_ADDR`, `AR_PROT`, `rsp_data_o`: 0.
- Asserting reset in any state returns to IDLE immediately. No response is produced for an in-flight request.

## Timing
- Grant handshake at edge 0. `AR_VALID` is high from cycle 1.
- Best-case latency:
  - `AR_READY` in cycle 1 → DATA in cycle 2.
  - `R_VALID` in cycle 2 → `rsp_valid_o` in cycle 3.
  - IDLE in cycle 4, which can grant again. Minimum issue interval is 4 cycles.
- `AR_VALID` is never dropped before `AR_READY` (AXI rule).
- `AR_VALID` and `R_READY` are never both high.
- `R_READY` is high only in DATA and DRAIN.
- `rsp_valid_o` and `req_ready_o` are at most one-hot. Both are 0 outside RESP and IDLE respectively.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,`NUM_REQ`-1,0. No requester waits more than `NUM_REQ`-1 transactions.
- The watchdog counter must be at least ⌈log2(`TIMEOUT_CYCLES`+1)⌉ bits wide and must not wrap.

## Test plan
- **Single request:** req 0 at `0x1000`, `AR_READY` and `R_VALID` immediate with `R_DATA`=`0xDEADBEEF`, `R_RESP`=00 → `rsp_valid_o`=01 at cycle 3 with data `0xDEADBEEF`, `rsp_err_o`=0.
- **Round-robin:** both requesters held valid for 4 transactions → grant order 0,1,0,1. Each `AR_ADDR` matches the granted requester.
- **Backpressure:** `AR_READY` delayed 5 cycles and `R_VALID` delayed 7 cycles → `AR_VALID` and `AR_ADDR` stay stable throughout. Response arrives 1 cycle after the R beat.
- **Error response:** `R_RESP`=10, then a separate transaction with `R_RESP`=11 → `rsp_err_o`=1 for each, with `R_DATA` forwarded.
- **Timeout:** `TIMEOUT_CYCLES`=16, no `R_VALID` → error pulse with data 0 after 16 DATA cycles. A late beat at +5 cycles is swallowed in DRAIN with no response. The next grant is issued only after that.
- **Reset mid-DATA:** drive `arst_ni` low while in DATA → all outputs go to their reset values asynchronously. After release, a new request completes normally from `rr_ptr`=0.
